// File: rtl/int_arbiter.sv
// -----------------------------------------------------------------------------
// int_arbiter
//   Interrupt arbiter sitting in front of the CP0 register block. Three
//   asynchronous request lines are synchronised, rising-edge detected and
//   latched as pending. Pending sources are filtered by IE/INM and the current
//   in-service level, arbitrated by fixed priority (3 highest), and handed to
//   the pipeline through a REQ/TAKE/GAP handshake.
//
// Ports
//   in_CLK       clock, posedge
//   in_RST       asynchronous active-low reset
//   in_IRQ[2:0]  raw requests, bit i = source i+1 (asynchronous)
//   in_IE        global interrupt enable from CP0
//   in_INM[3:0]  mask from CP0, bit k masks source k (bit 0 unused)
//   in_eret      ERET retiring this cycle
//   in_flush_ok  pipeline accepts a redirect this cycle
//   out_code     cause code to CP0 (0 = none)
//   out_BK       one-cycle take pulse
//   out_NIE      IE value CP0 loads on BK / ERET
//   out_vector   handler address, valid while out_BK = 1
//   out_pending  pending register (debug)
//   out_level    current in-service level (0 = none)
//
// Handshake: out_code goes non-zero in REQ and stays frozen until the
// pipeline signals in_flush_ok; the following cycle (TAKE) carries out_BK=1
// for exactly one cycle, then GAP forces out_code back to 0 so every take is
// seen by CP0 as a fresh 0->nonzero edge.
// -----------------------------------------------------------------------------
module int_arbiter #(
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic        in_CLK,
   input  logic        in_RST,
   input  logic [2:0]  in_IRQ,
   input  logic        in_IE,
   input  logic [3:0]  in_INM,
   input  logic        in_eret,
   input  logic        in_flush_ok,
   output logic [1:0]  out_code,
   output logic        out_BK,
   output logic        out_NIE,
   output logic [31:0] out_vector,
   output logic [2:0]  out_pending,
   output logic [1:0]  out_level
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_TAKE = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   logic [2:0]  sync1_q, sync1_d;
   logic [2:0]  sync2_q, sync2_d;
   logic [2:0]  sync3_q, sync3_d;
   logic [2:0]  pending_q, pending_d;
   logic [2:0]  isr_q, isr_d;
   logic [1:0]  state_q, state_d;
   logic [1:0]  code_q, code_d;
   logic        bk_q, bk_d;
   logic        nie_q, nie_d;
   logic [31:0] vector_q, vector_d;

   logic [2:0]  irq_edge;
   logic [2:0]  elig;
   logic [2:0]  isr_top;
   logic [2:0]  code_onehot;
   logic [2:0]  pend_clr;
   logic [2:0]  isr_set;
   logic [1:0]  level;
   logic [1:0]  winner;
   logic        req_abort;

   assign irq_edge = sync2_q & ~sync3_q;

   // Current level and the one-hot of the ISR bit that ERET would retire.
   always_comb begin
      level   = 2'd0;
      isr_top = 3'b000;
      if (isr_q[2]) begin
         level   = 2'd3;
         isr_top = 3'b100;
      end else if (isr_q[1]) begin
         level   = 2'd2;
         isr_top = 3'b010;
      end else if (isr_q[0]) begin
         level   = 2'd1;
         isr_top = 3'b001;
      end
   end

   // Source k is eligible only above the level currently in service.
   assign elig[0] = pending_q[0] & ~in_INM[1] & in_IE & (level == 2'd0);
   assign elig[1] = pending_q[1] & ~in_INM[2] & in_IE & (level <  2'd2);
   assign elig[2] = pending_q[2] & ~in_INM[3] & in_IE & (level <  2'd3);

   always_comb begin
      winner = 2'd0;
      if (elig[2])      winner = 2'd3;
      else if (elig[1]) winner = 2'd2;
      else if (elig[0]) winner = 2'd1;
   end

   always_comb begin
      code_onehot = 3'b000;
      case (code_q)
         2'd1:    code_onehot = 3'b001;
         2'd2:    code_onehot = 3'b010;
         2'd3:    code_onehot = 3'b100;
         default: code_onehot = 3'b000;
      endcase
   end

   assign req_abort = ~in_IE | in_INM[code_q];

   always_comb begin
      sync1_d  = in_IRQ;
      sync2_d  = sync1_q;
      sync3_d  = sync2_q;
      state_d  = state_q;
      code_d   = code_q;
      bk_d     = 1'b0;
      nie_d    = nie_q;
      vector_d = 32'h0;
      pend_clr = 3'b000;
      isr_set  = 3'b000;

      case (state_q)
         ST_IDLE: begin
            code_d = 2'd0;
            if (winner != 2'd0) begin
               code_d  = winner;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // The latched code is frozen; a later higher source waits.
            if (req_abort) begin
               code_d  = 2'd0;
               state_d = ST_IDLE;
            end else if (in_flush_ok) begin
               state_d  = ST_TAKE;
               bk_d     = 1'b1;
               nie_d    = 1'b0;
               vector_d = VEC_BASE + VEC_STRIDE * {30'd0, code_q};
            end
         end
         ST_TAKE: begin
            pend_clr = code_onehot;
            isr_set  = code_onehot;
            code_d   = 2'd0;
            state_d  = ST_GAP;
         end
         default: begin
            code_d  = 2'd0;
            state_d = ST_IDLE;
         end
      endcase

      // ERET re-enables interrupts, except in the one cycle that loads
      // out_NIE=0 for the TAKE pulse, which must win.
      if (in_eret && !bk_d) nie_d = 1'b1;
   end

   // A fresh edge beats the TAKE clear; ERET retires the top bit as it
   // stood before any set from TAKE in the same cycle.
   assign pending_d = (pending_q & ~pend_clr) | irq_edge;
   assign isr_d     = (isr_q & ~(in_eret ? isr_top : 3'b000)) | isr_set;

   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         sync1_q   <= 3'b000;
         sync2_q   <= 3'b000;
         sync3_q   <= 3'b000;
         pending_q <= 3'b000;
         isr_q     <= 3'b000;
         state_q   <= ST_IDLE;
         code_q    <= 2'd0;
         bk_q      <= 1'b0;
         nie_q     <= 1'b1;
         vector_q  <= 32'h0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         sync3_q   <= sync3_d;
         pending_q <= pending_d;
         isr_q     <= isr_d;
         state_q   <= state_d;
         code_q    <= code_d;
         bk_q      <= bk_d;
         nie_q     <= nie_d;
         vector_q  <= vector_d;
      end
   end

   assign out_code    = code_q;
   assign out_BK      = bk_q;
   assign out_NIE     = nie_q;
   assign out_vector  = vector_q;
   assign out_pending = pending_q;
   assign out_level   = level;

endmodule

// File: tb/tb_int_arbiter.sv
// -----------------------------------------------------------------------------
// tb_int_arbiter
//   Scoreboard bench for int_arbiter. Stimulus tasks update a source-level
//   model (pending set, in-service set, mask) and push the expected take
//   {code, vector} into exp_q; a monitor pops on every out_BK pulse.
// -----------------------------------------------------------------------------
module tb_int_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_irq;
  logic        in_ie;
  logic [3:0]  in_inm;
  logic        in_eret;
  logic        in_flush_ok;
  logic [1:0]  out_code;
  logic        out_bk;
  logic        out_nie;
  logic [31:0] out_vector;
  logic [2:0]  out_pending;
  logic [1:0]  out_level;

  int_arbiter dut (
    .in_CLK      (clk),
    .in_RST      (rst_n),
    .in_IRQ      (in_irq),
    .in_IE       (in_ie),
    .in_INM      (in_inm),
    .in_eret     (in_eret),
    .in_flush_ok (in_flush_ok),
    .out_code    (out_code),
    .out_BK      (out_bk),
    .out_NIE     (out_nie),
    .out_vector  (out_vector),
    .out_pending (out_pending),
    .out_level   (out_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];

  // model state: indexed by source number
  logic [3:1] m_pend;
  logic [3:1] m_isr;
  logic [3:1] m_inm;
  logic       m_nie;

  logic rand_flush;
  logic flush_fixed;
  logic gap_next;

  always @(negedge clk) begin
    if (rand_flush) in_flush_ok = ($urandom_range(0, 3) != 0);
    else            in_flush_ok = flush_fixed;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mlevel();
    for (int k = 3; k >= 1; k--) if (m_isr[k]) return k;
    return 0;
  endfunction

  // Takes everything the rules allow, highest eligible source first.
  task automatic resolve();
    int best;
    forever begin
      best = 0;
      for (int k = 1; k <= 3; k++)
        if (m_pend[k] && !m_inm[k] && k > mlevel()) best = k;
      if (best == 0) break;
      exp_q.push_back({best[1:0], 32'h100 + best * 32'h10});
      m_pend[best] = 1'b0;
      m_isr[best]  = 1'b1;
      m_nie        = 1'b0;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst_n) begin
      gap_next = 1'b0;
    end else begin
      if (gap_next) begin
        chk("gap_code", 32'(out_code), 32'd0);
        chk("gap_bk", 32'(out_bk), 32'd0);
        gap_next = 1'b0;
      end
      if (out_bk) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bk: got code=%0d vector=%0h expected no take at %0t",
                   out_code, out_vector, $time);
        end else begin
          e = exp_q.pop_front();
          chk("take_code", 32'(out_code), 32'(e[33:32]));
          chk("take_vector", out_vector, e[31:0]);
          chk("take_nie", 32'(out_nie), 32'd0);
        end
        gap_next = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic [2:0] mask, input bit do_resolve);
    @(negedge clk);
    in_irq = in_irq | mask;
    m_pend = m_pend | mask;
    if (do_resolve) resolve();
    repeat (3) @(negedge clk);
    in_irq = in_irq & ~mask;
  endtask

  task automatic do_eret();
    @(negedge clk);
    for (int k = 3; k >= 1; k--) if (m_isr[k]) begin m_isr[k] = 1'b0; break; end
    m_nie = 1'b1;
    resolve();
    in_eret = 1'b1;
    @(negedge clk);
    in_eret = 1'b0;
  endtask

  task automatic set_inm(input logic [3:0] v);
    @(negedge clk);
    m_inm  = v[3:1];
    in_inm = v;
    resolve();
  endtask

  task automatic settle(input string tag);
    repeat (20) @(negedge clk);
    chk({tag, "_pending"}, 32'(out_pending), 32'(m_pend));
    chk({tag, "_level"}, 32'(out_level), 32'(mlevel()));
    chk({tag, "_nie"}, 32'(out_nie), 32'(m_nie));
    chk({tag, "_code_idle"}, 32'(out_code), 32'd0);
  endtask

  task automatic drain();
    set_inm(4'b0000);
    settle("drain_unmask");
    while (m_isr != 3'b000) begin
      do_eret();
      settle("drain");
    end
  endtask

  task automatic model_reset();
    m_pend = 3'b000;
    m_isr  = 3'b000;
    m_inm  = 3'b000;
    m_nie  = 1'b1;
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code"}, 32'(out_code), 32'd0);
    chk({tag, "_bk"}, 32'(out_bk), 32'd0);
    chk({tag, "_nie"}, 32'(out_nie), 32'd1);
    chk({tag, "_vector"}, out_vector, 32'd0);
    chk({tag, "_level"}, 32'(out_level), 32'd0);
    chk({tag, "_pending"}, 32'(out_pending), 32'd0);
  endtask

  initial begin
    int first;
    int r;
    logic [2:0] m;
    rst_n = 1'b0;
    in_irq = 3'b000;
    in_ie = 1'b1;
    in_inm = 4'b0000;
    in_eret = 1'b0;
    rand_flush = 1'b0;
    flush_fixed = 1'b1;
    in_flush_ok = 1'b1;
    gap_next = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: single source 1, code within 4 cycles of the raw edge
    @(negedge clk);
    in_irq = 3'b001;
    m_pend[1] = 1'b1;
    resolve();
    first = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (first == 0 && out_code == 2'd1) first = i;
    end
    chk("t1_code_latency_ok", 32'(first != 0), 32'd1);
    in_irq = 3'b000;
    settle("t1");
    drain();

    // T2: sources 1 and 3 together, 3 first, 1 after ERET
    pulse(3'b101, 1'b1);
    settle("t2_first");
    do_eret();
    settle("t2_second");
    drain();

    // T3: masked source 2 stays pending until unmasked
    set_inm(4'b0100);
    pulse(3'b010, 1'b1);
    settle("t3_masked");
    set_inm(4'b0000);
    settle("t3_unmasked");

    // T4: level 2 in service; source 1 waits, source 3 nests
    pulse(3'b001, 1'b1);
    settle("t4_low");
    pulse(3'b100, 1'b1);
    settle("t4_nest");
    do_eret();
    settle("t4_eret");
    drain();

    // T5: REQ held without flush_ok, aborted by IE=0, then taken
    flush_fixed = 1'b0;
    pulse(3'b010, 1'b0);
    first = 0;
    for (int i = 0; i < 10 && first == 0; i++) begin
      if (out_code != 2'd0) first = 1;
      else @(negedge clk);
    end
    chk("t5_req_seen", 32'(first), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_code_held", 32'(out_code), 32'd2);
      chk("t5_no_bk", 32'(out_bk), 32'd0);
      @(negedge clk);
    end
    in_ie = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_abort_code", 32'(out_code), 32'd0);
    chk("t5_abort_pending", 32'(out_pending), 32'b010);
    in_ie = 1'b1;
    flush_fixed = 1'b1;
    resolve();
    settle("t5_take");
    drain();

    // T6: asynchronous reset while in REQ
    flush_fixed = 1'b0;
    pulse(3'b001, 1'b0);
    first = 0;
    for (int i = 0; i < 10 && first == 0; i++) begin
      if (out_code != 2'd0) first = 1;
      else @(negedge clk);
    end
    chk("t6_req_seen", 32'(first), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush_fixed = 1'b1;
    settle("t6_after");

    // Random phase
    rand_flush = 1'b1;
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        m = 3'b001 << $urandom_range(0, 2);
        pulse(m, 1'b1);
      end else if (r < 7) begin
        do_eret();
      end else if (r < 9) begin
        set_inm(4'($urandom_range(0, 15)));
      end else begin
        m = 3'($urandom_range(1, 7));
        pulse(m, 1'b1);
      end
      settle("rand");
    end
    rand_flush = 1'b0;
    drain();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
